// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter slice.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NREG       = 32;
  localparam int unsigned DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Identifies which writeback requester won the most recent grant.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: set at issue, cleared at commit, set wins on collision.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  busy1,
  output logic                  busy2
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Clear first so a same-edge set for a newer producer overrides it.
  always_comb begin
    pending_nxt = pending;
    if (clr_en) begin
      pending_nxt[clr_rd] = 1'b0;
    end
    if (set_en && (set_rd != REG_ZERO)) begin
      pending_nxt[set_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  assign busy1 = pending[rs1];
  assign busy2 = pending[rs2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU (A) and memory (B).
// Optional same-cycle bypass of the committing write is enabled by REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned W    = 32,
  parameter int unsigned NREG = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [REG_ADDR_W-1:0] a_rd,
  input  logic [W-1:0]          a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_rd,
  input  logic [W-1:0]          b_data,
  output logic                  regwrite,
  output logic [REG_ADDR_W-1:0] wr_out,
  output logic [W-1:0]          write_data_out,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1_in,
  input  logic [REG_ADDR_W-1:0] rs2_in,
  output logic                  busy1_out,
  output logic                  busy2_out,
  output logic                  fwd1_valid,
  output logic                  fwd2_valid,
  output logic [W-1:0]          fwd1_data,
  output logic [W-1:0]          fwd2_data
);

  port_e   last_grant;
  port_e   last_grant_nxt;
  logic    grant_a;
  logic    grant_b;
  wb_req_t req_a;
  wb_req_t req_b;
  wb_req_t win;
  logic    sb_busy1;
  logic    sb_busy2;

  always_comb begin
    req_a.valid = a_valid;
    req_a.rd    = a_rd;
    req_a.data  = DATA_W'(a_data);
    req_b.valid = b_valid;
    req_b.rd    = b_rd;
    req_b.data  = DATA_W'(b_data);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant <= PORT_B;
    end else begin
      last_grant <= last_grant_nxt;
    end
  end

  // A wins when alone or when B was served last; B wins otherwise.
  always_comb begin
    grant_a        = 1'b0;
    grant_b        = 1'b0;
    last_grant_nxt = last_grant;
    if (req_a.valid && (!req_b.valid || (last_grant == PORT_B))) begin
      grant_a = 1'b1;
    end else if (req_b.valid) begin
      grant_b = 1'b1;
    end
    if (grant_a) begin
      last_grant_nxt = PORT_A;
    end else if (grant_b) begin
      last_grant_nxt = PORT_B;
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign win     = grant_a ? req_a : req_b;

  // Registered write port; r0 writes are accepted but never enabled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regwrite       <= 1'b0;
      wr_out         <= REG_ZERO;
      write_data_out <= '0;
    end else if (grant_a || grant_b) begin
      regwrite       <= win.valid && (win.rd != REG_ZERO);
      wr_out         <= win.rd;
      write_data_out <= W'(win.data);
    end else begin
      regwrite       <= 1'b0;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS(NREG)
  ) u_scoreboard (
    .clock (clock),
    .reset (reset),
    .set_en(issue_valid),
    .set_rd(issue_rd),
    .clr_en(regwrite),
    .clr_rd(wr_out),
    .rs1   (rs1_in),
    .rs2   (rs2_in),
    .busy1 (sb_busy1),
    .busy2 (sb_busy2)
  );

`ifdef REGFILE_WB_BYPASS_EN
  always_comb begin
    fwd1_valid = regwrite && (wr_out == rs1_in) && (rs1_in != REG_ZERO);
    fwd2_valid = regwrite && (wr_out == rs2_in) && (rs2_in != REG_ZERO);
    fwd1_data  = write_data_out;
    fwd2_data  = write_data_out;
    busy1_out  = sb_busy1 && !fwd1_valid;
    busy2_out  = sb_busy2 && !fwd2_valid;
  end
`else
  always_comb begin
    fwd1_valid = 1'b0;
    fwd2_valid = 1'b0;
    fwd1_data  = '0;
    fwd2_data  = '0;
    busy1_out  = sb_busy1;
    busy2_out  = sb_busy2;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic vs a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int unsigned W = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0, issue_valid = 1'b0;
  logic [4:0]    a_rd = '0, b_rd = '0, issue_rd = '0, rs1_in = '0, rs2_in = '0;
  logic [W-1:0]  a_data = '0, b_data = '0;
  logic          a_ready, b_ready, regwrite, busy1_out, busy2_out, fwd1_valid, fwd2_valid;
  logic [4:0]    wr_out;
  logic [W-1:0]  write_data_out, fwd1_data, fwd2_data;

  int n_cmp = 0;
  int n_err = 0;

  regfile_wb_arbiter #(.W(W), .NREG(32)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .regwrite(regwrite), .wr_out(wr_out), .write_data_out(write_data_out),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_in(rs1_in), .rs2_in(rs2_in),
    .busy1_out(busy1_out), .busy2_out(busy2_out),
    .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who has priority, what was written, which registers await a write.
  bit          m_a_first = 1'b1;
  bit [31:0]   m_pend = '0;
  bit          m_rw = 1'b0;
  bit [4:0]    m_wr = '0;
  bit [31:0]   m_data = '0;

  function automatic bit model_grant_a();
    return a_valid && (!b_valid || m_a_first);
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_a_first <= 1'b1;
      m_pend    <= '0;
      m_rw      <= 1'b0;
      m_wr      <= '0;
      m_data    <= '0;
    end else begin
      if (m_rw) m_pend[m_wr] <= 1'b0;
      if (issue_valid && issue_rd != 0) m_pend[issue_rd] <= 1'b1;
      if (model_grant_a()) begin
        m_rw <= (a_rd != 0); m_wr <= a_rd; m_data <= a_data; m_a_first <= 1'b0;
      end else if (b_valid) begin
        m_rw <= (b_rd != 0); m_wr <= b_rd; m_data <= b_data; m_a_first <= 1'b1;
      end else begin
        m_rw <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    bit ga, gb, f1, f2;
    logic [31:0] fd;
    ga = model_grant_a();
    gb = b_valid && !ga;
`ifdef REGFILE_WB_BYPASS_EN
    f1 = m_rw && (m_wr == rs1_in) && (rs1_in != 0);
    f2 = m_rw && (m_wr == rs2_in) && (rs2_in != 0);
    fd = m_data;
`else
    f1 = 1'b0; f2 = 1'b0; fd = '0;
`endif
    chk("m_a_ready", {31'd0, a_ready}, {31'd0, ga});
    chk("m_b_ready", {31'd0, b_ready}, {31'd0, gb});
    chk("m_regwrite", {31'd0, regwrite}, {31'd0, m_rw});
    chk("m_wr_out", {27'd0, wr_out}, {27'd0, m_wr});
    chk("m_wdata", write_data_out, m_data);
    chk("m_busy1", {31'd0, busy1_out}, {31'd0, m_pend[rs1_in] && !f1});
    chk("m_busy2", {31'd0, busy2_out}, {31'd0, m_pend[rs2_in] && !f2});
    chk("m_fwd1_valid", {31'd0, fwd1_valid}, {31'd0, f1});
    chk("m_fwd2_valid", {31'd0, fwd2_valid}, {31'd0, f2});
    chk("m_fwd1_data", fwd1_data, fd);
    chk("m_fwd2_data", fwd2_data, fd);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic pulse_reset();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  exp_wr [4] = '{1, 5, 2, 6};
    bit  exp_ga [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit  acc_a, acc_b;

    // Reset values
    rs1_in = 5'd3; rs2_in = 5'd5;
    repeat (3) @(posedge clock);
    mid();
    chk("rst_regwrite", {31'd0, regwrite}, 32'd0);
    chk("rst_wr_out", {27'd0, wr_out}, 32'd0);
    chk("rst_busy1", {31'd0, busy1_out}, 32'd0);
    chk("rst_busy2", {31'd0, busy2_out}, 32'd0);

    // First write after reset, latency 1
    tick();
    reset = 1'b1;
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hA5;
    mid();
    chk("first_a_ready", {31'd0, a_ready}, 32'd1);
    chk("first_b_ready", {31'd0, b_ready}, 32'd0);
    tick();
    a_valid = 1'b0;
    mid();
    chk("first_regwrite", {31'd0, regwrite}, 32'd1);
    chk("first_wr_out", {27'd0, wr_out}, 32'd3);
    chk("first_wdata", write_data_out, 32'hA5);

    // Round-robin with both requesters held until accepted
    pulse_reset();
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h101;
    b_valid = 1'b1; b_rd = 5'd5; b_data = 32'h205;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("rr_grant_a", {31'd0, a_ready}, {31'd0, exp_ga[i]});
      chk("rr_overlap", {31'd0, a_ready & b_ready}, 32'd0);
      if (i > 0) chk("rr_wr_out", {27'd0, wr_out}, 32'(exp_wr[i-1]));
      acc_a = a_ready; acc_b = b_ready;
      tick();
      if (acc_a) begin a_rd = a_rd + 5'd1; a_data = 32'h100 + 32'(a_rd); end
      if (acc_b) begin b_rd = b_rd + 5'd1; b_data = 32'h200 + 32'(b_rd); end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    mid();
    chk("rr_wr_last", {27'd0, wr_out}, 32'(exp_wr[3]));
    chk("rr_regwrite_last", {31'd0, regwrite}, 32'd1);

    // Write to r0 is accepted and dropped
    tick();
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'hFFFF;
    mid();
    chk("r0_b_ready", {31'd0, b_ready}, 32'd1);
    tick();
    b_valid = 1'b0;
    mid();
    chk("r0_regwrite", {31'd0, regwrite}, 32'd0);

    // Scoreboard set then clear
    issue_valid = 1'b1; issue_rd = 5'd7; rs1_in = 5'd7;
    tick();
    issue_valid = 1'b0;
    mid();
    chk("sb_set_busy", {31'd0, busy1_out}, 32'd1);
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h77;
    tick();
    a_valid = 1'b0;
    mid();
    chk("sb_commit_regwrite", {31'd0, regwrite}, 32'd1);
`ifndef REGFILE_WB_BYPASS_EN
    chk("sb_commit_busy", {31'd0, busy1_out}, 32'd1);
`endif
    tick();
    mid();
    chk("sb_clear_busy", {31'd0, busy1_out}, 32'd0);

    // Set and clear of the same register on one edge: set wins
    issue_valid = 1'b1; issue_rd = 5'd9; rs2_in = 5'd9;
    a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h99;
    tick();
    a_valid = 1'b0;
    mid();
    chk("coll_regwrite", {31'd0, regwrite}, 32'd1);
    chk("coll_wr_out", {27'd0, wr_out}, 32'd9);
    tick();
    issue_valid = 1'b0;
    mid();
    chk("coll_busy_kept", {31'd0, busy2_out}, 32'd1);

    // Commit-cycle visibility of a pending register
    issue_valid = 1'b1; issue_rd = 5'd4;
    tick();
    issue_valid = 1'b0;
    a_valid = 1'b1; a_rd = 5'd4; a_data = 32'h44; rs1_in = 5'd4;
    tick();
    a_valid = 1'b0;
    mid();
`ifdef REGFILE_WB_BYPASS_EN
    chk("byp_fwd1_valid", {31'd0, fwd1_valid}, 32'd1);
    chk("byp_fwd1_data", fwd1_data, 32'h44);
    chk("byp_busy1", {31'd0, busy1_out}, 32'd0);
`else
    chk("byp_fwd1_valid", {31'd0, fwd1_valid}, 32'd0);
    chk("byp_fwd1_data", fwd1_data, 32'h0);
    chk("byp_busy1", {31'd0, busy1_out}, 32'd1);
`endif

    // Asynchronous reset in the middle of a registered write
    issue_valid = 1'b1; issue_rd = 5'd12; rs1_in = 5'd12;
    a_valid = 1'b1; a_rd = 5'd11; a_data = 32'hBB;
    tick();
    issue_valid = 1'b0; a_valid = 1'b0;
    chk("arst_pre_regwrite", {31'd0, regwrite}, 32'd1);
    chk("arst_pre_busy", {31'd0, busy1_out}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("arst_regwrite", {31'd0, regwrite}, 32'd0);
    chk("arst_busy", {31'd0, busy1_out}, 32'd0);
    chk("arst_busy2", {31'd0, busy2_out}, 32'd0);
    chk("arst_wr_out", {27'd0, wr_out}, 32'd0);
    tick();
    tick();
    reset = 1'b1;

    // Randomized traffic; requesters hold their request until accepted
    acc_a = 1'b1; acc_b = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (!a_valid || acc_a) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_rd    = 5'($urandom_range(0, 31));
        a_data  = $urandom;
      end
      if (!b_valid || acc_b) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_rd    = 5'($urandom_range(0, 31));
        b_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = 5'($urandom_range(0, 31));
      rs1_in      = $urandom_range(0, 1) ? wr_out : 5'($urandom_range(0, 31));
      rs2_in      = $urandom_range(0, 1) ? issue_rd : 5'($urandom_range(0, 31));
      mid();
      acc_a = a_ready; acc_b = b_ready;
      if (c == 1500) begin
        reset = 1'b0;
        #1 reset = 1'b1;
      end
      tick();
    end

    a_valid = 1'b0; b_valid = 1'b0; issue_valid = 1'b0;
    mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
